// File: rtl/md_unit_pkg.sv
// Shared op codes and types for the multiply/divide unit.
// No logic: constants, FSM state type and a small op-classifier helper.
// Imported by md_calc and md_unit.
package md_unit_pkg;

  // md_op encodings, alongside the ALU op codes
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for the ops that occupy the unit for several cycles
  function automatic logic is_md_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the divide ops (selects the divide latency)
  function automatic logic is_md_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide result generator (hi/lo pair for one op).
// Latency: zero cycles, pure combinational.
// Backpressure: none; the caller decides when the result is captured.
module md_calc
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

  logic                   mul_signed;
  logic                   div_signed;
  logic [2*WIDTH-1:0]     a_ext;
  logic [2*WIDTH-1:0]     b_ext;
  logic [2*WIDTH-1:0]     prod;
  logic                   a_neg;
  logic                   b_neg;
  logic [WIDTH-1:0]       a_mag;
  logic [WIDTH-1:0]       b_mag;
  logic [WIDTH-1:0]       div_den;
  logic [WIDTH-1:0]       q_mag;
  logic [WIDTH-1:0]       r_mag;
  logic [WIDTH-1:0]       quot;
  logic [WIDTH-1:0]       rem;
  logic                   div_by_zero;
  logic                   min_by_neg1;

  // Multiply: extend to 2*WIDTH so the truncated product equals the full signed/unsigned product
  always_comb begin
    mul_signed = (md_op == MD_MULT);
    a_ext      = mul_signed ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
    b_ext      = mul_signed ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
    prod       = a_ext * b_ext;
  end

  // Divide on magnitudes, then restore signs: quotient truncates toward zero, remainder follows the dividend
  always_comb begin
    div_signed  = (md_op == MD_DIV);
    a_neg       = div_signed & A[WIDTH-1];
    b_neg       = div_signed & B[WIDTH-1];
    a_mag       = a_neg ? (~A + 1'b1) : A;
    b_mag       = b_neg ? (~B + 1'b1) : B;
    div_by_zero = (B == '0);
    // Keep the divider operand non-zero; the zero-divisor result is substituted below
    div_den     = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag       = a_mag / div_den;
    r_mag       = a_mag % div_den;
    quot        = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem         = a_neg ? (~r_mag + 1'b1) : r_mag;
    // MIN / -1 overflows the quotient; it is defined to wrap to MIN with zero remainder
    min_by_neg1 = div_signed && (A == MIN_VAL) && (B == ALL_ONE);
  end

  // Select the result pair for the requested op
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (md_op)
      MD_MULT, MD_MULTU: begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
      end
      MD_DIV, MD_DIVU: begin
        if (div_by_zero) begin
          res_hi = A;
          res_lo = ALL_ONE;
        end else if (min_by_neg1) begin
          res_hi = '0;
          res_lo = MIN_VAL;
        end else begin
          res_hi = rem;
          res_lo = quot;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES busy cycles; mthi/mtlo write next edge.
// Backpressure: busy is the stall; a start arriving while busy is dropped without side effects.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             idle;
  logic             accept_arith;
  logic             accept_mthi;
  logic             accept_mtlo;
  logic             last_cycle;
  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;

  md_calc #(
    .WIDTH (WIDTH)
  ) u_md_calc (
    .md_op  (md_op),
    .A      (A),
    .B      (B),
    .res_hi (calc_hi),
    .res_lo (calc_lo)
  );

  // Decode which request, if any, is taken this cycle; everything is gated by idle
  always_comb begin
    idle         = (state_q == ST_IDLE);
    accept_arith = start && idle && is_md_arith(md_op);
    accept_mthi  = start && idle && (md_op == MD_MTHI);
    accept_mtlo  = start && idle && (md_op == MD_MTLO);
    last_cycle   = (state_q == ST_RUN) && (cnt_q == CNT_ONE);
  end

  // State, counter, pending result and HI/LO registers; reset wins over any start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Next state: leave IDLE on an accepted arithmetic op, return when the last busy cycle ends
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_arith) state_d = ST_RUN;
      ST_RUN:  if (last_cycle)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter and pending capture: the full result is latched at accept, then only the count moves
  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (accept_arith) begin
      cnt_d     = is_md_div(md_op) ? DIV_N : MULT_N;
      pend_hi_d = calc_hi;
      pend_lo_d = calc_lo;
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // HI/LO commit: pending values at the end of the last busy cycle, or direct moves while idle
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (last_cycle) begin
      hi_d = pend_hi_q;
      lo_d = pend_lo_q;
    end else begin
      if (accept_mthi) hi_d = A;
      if (accept_mtlo) lo_d = A;
    end
  end

  // Outputs come straight from state and architectural registers
  always_comb begin
    busy = (state_q == ST_RUN);
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule
